// File: rtl/ts_packet_source_if.sv
// rtl/ts_packet_source_if.sv - per-channel TS byte-stream bundle
// Signals: valid/byte_data/sop/eop driven by the packet source, ready driven by the sink.
// byte_data carries channel c on bits [8c+7:8c].
interface ts_packet_source_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   valid;
  logic [NUM_CH-1:0]   ready;
  logic [NUM_CH*8-1:0] byte_data;
  logic [NUM_CH-1:0]   sop;
  logic [NUM_CH-1:0]   eop;

  modport master (output valid, output byte_data, output sop, output eop, input ready);
  modport slave  (input valid, input byte_data, input sop, input eop, output ready);
endinterface

// File: rtl/ts_packet_source.sv
// rtl/ts_packet_source.sv - multi-channel MPEG-2 TS packet generator with loss injection
// Ports: clk, rstn (async active-low), enable (level start/continue), ts (master modport:
// valid/byte_data/sop/eop out, ready in, one lane per channel), eof (sticky, all channels done).
module ts_packet_source #(
  parameter int                NUM_CH      = 4,
  parameter int                NUM_PKTS    = 16,
  parameter int                GAP_CYCLES  = 2,
  parameter logic [12:0]       BASE_PID    = 13'h0100,
  parameter int                LOSS_PERIOD = 0,
  parameter logic [NUM_CH-1:0] LOSS_MASK   = {NUM_CH{1'b0}}
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  ts_packet_source_if.master ts,
  output logic               eof
);
  localparam int              GW        = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0]   GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam int              LP        = (LOSS_PERIOD > 0) ? LOSS_PERIOD : 1;
  localparam logic [31:0]     PKT_LIMIT = 32'(NUM_PKTS);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  logic [NUM_CH-1:0] w_done;
  logic              r_eof;

  function automatic logic [7:0] f_byte(input logic [7:0] k, input logic [12:0] pid,
                                        input logic [3:0] cc, input logic [31:0] pkt);
    case (k)
      8'd0:    f_byte = 8'h47;
      8'd1:    f_byte = {3'b010, pid[12:8]};
      8'd2:    f_byte = pid[7:0];
      8'd3:    f_byte = {4'b0001, cc};
      default: f_byte = k - 8'd4 + pkt[7:0];
    endcase
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [12:0] L_PID  = 13'(BASE_PID + c);
    localparam bit          L_LOSS = (LOSS_PERIOD > 0) && LOSS_MASK[c];

    state_t        r_state, w_state;
    logic [7:0]    r_byte_idx, w_byte_idx;
    logic [31:0]   r_pkt, w_pkt;
    logic [3:0]    r_cc, w_cc;
    logic [GW-1:0] r_gap, w_gap;
    logic          r_valid, w_valid;
    logic [7:0]    r_data, w_data;
    logic          r_sop, w_sop;
    logic          r_eop, w_eop;
    logic          w_go;
    logic          w_drop;

    always_comb begin
      w_state    = r_state;
      w_byte_idx = r_byte_idx;
      w_pkt      = r_pkt;
      w_cc       = r_cc;
      w_gap      = r_gap;
      w_valid    = r_valid;
      w_data     = r_data;
      w_sop      = r_sop;
      w_eop      = r_eop;
      w_go       = 1'b0;
      w_drop     = 1'b0;

      case (r_state)
        IDLE: w_go = enable;
        SEND: begin
          if (ts.ready[c]) begin
            if (r_byte_idx == 8'd187) begin
              w_pkt      = r_pkt + 32'd1;
              w_cc       = r_cc + 4'd1;
              w_valid    = 1'b0;
              w_data     = 8'h00;
              w_sop      = 1'b0;
              w_eop      = 1'b0;
              w_byte_idx = 8'd0;
              if (GAP_CYCLES > 0) begin
                w_state = GAP;
                w_gap   = '0;
              end else if ((NUM_PKTS != 0) && (w_pkt == PKT_LIMIT)) begin
                w_state = DONE;
              end else begin
                // No gap: decide on the next packet now so sop follows eop directly.
                w_state = IDLE;
                w_go    = enable;
              end
            end else begin
              w_byte_idx = r_byte_idx + 8'd1;
              w_data     = f_byte(w_byte_idx, L_PID, r_cc, r_pkt);
              w_sop      = 1'b0;
              w_eop      = (w_byte_idx == 8'd187);
            end
          end
        end
        GAP: begin
          if (r_gap == GAP_LAST) begin
            if ((NUM_PKTS != 0) && (r_pkt == PKT_LIMIT)) begin
              w_state = DONE;
            end else begin
              // Launch from the last gap cycle so the idle stretch is exactly GAP_CYCLES.
              w_state = IDLE;
              w_go    = enable;
            end
          end else begin
            w_gap = r_gap + GW'(1);
          end
        end
        default: ;
      endcase

      // Start packet w_pkt: either emit it or account for it as a dropped packet.
      if (w_go) begin
        w_drop = L_LOSS && (((w_pkt + 32'd1) % 32'(LP)) == 32'd0);
        if (w_drop) begin
          w_pkt = w_pkt + 32'd1;
          w_cc  = w_cc + 4'd1;
          if (GAP_CYCLES > 0) begin
            w_state = GAP;
            w_gap   = '0;
          end else if ((NUM_PKTS != 0) && (w_pkt == PKT_LIMIT)) begin
            w_state = DONE;
          end else begin
            w_state = IDLE;
          end
        end else begin
          w_state    = SEND;
          w_byte_idx = 8'd0;
          w_valid    = 1'b1;
          w_data     = 8'h47;
          w_sop      = 1'b1;
          w_eop      = 1'b0;
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_state    <= IDLE;
        r_byte_idx <= 8'd0;
        r_pkt      <= 32'd0;
        r_cc       <= 4'd0;
        r_gap      <= '0;
        r_valid    <= 1'b0;
        r_data     <= 8'h00;
        r_sop      <= 1'b0;
        r_eop      <= 1'b0;
      end else begin
        r_state    <= w_state;
        r_byte_idx <= w_byte_idx;
        r_pkt      <= w_pkt;
        r_cc       <= w_cc;
        r_gap      <= w_gap;
        r_valid    <= w_valid;
        r_data     <= w_data;
        r_sop      <= w_sop;
        r_eop      <= w_eop;
      end
    end

    assign ts.valid[c]           = r_valid;
    assign ts.byte_data[8*c +: 8] = r_data;
    assign ts.sop[c]             = r_sop;
    assign ts.eop[c]             = r_eop;
    assign w_done[c]             = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_eof <= 1'b0;
    end else if ((NUM_PKTS != 0) && (&w_done)) begin
      r_eof <= 1'b1;
    end
  end

  assign eof = r_eof;
endmodule

// File: tb/tb_ts_packet_source.sv
// tb/tb_ts_packet_source.sv - self-checking bench for ts_packet_source
module tb_ts_packet_source;
  localparam int          A_CH   = 4;
  localparam int          A_PKTS = 4;
  localparam int          A_GAP  = 2;
  localparam logic [12:0] A_PID  = 13'h0100;
  localparam int          A_LP   = 2;
  localparam logic [3:0]  A_MASK = 4'b0001;
  localparam int          B_CH   = 2;
  localparam int          B_PKTS = 17;
  localparam int          B_GAP  = 0;
  localparam logic [12:0] B_PID  = 13'h1FFF;
  localparam int          NID    = A_CH + B_CH;

  logic clk = 1'b0;
  logic rstn, en_a, en_b, eof_a, eof_b;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  ts_packet_source_if #(.NUM_CH(A_CH)) ifa ();
  ts_packet_source_if #(.NUM_CH(B_CH)) ifb ();

  ts_packet_source #(.NUM_CH(A_CH), .NUM_PKTS(A_PKTS), .GAP_CYCLES(A_GAP), .BASE_PID(A_PID),
                     .LOSS_PERIOD(A_LP), .LOSS_MASK(A_MASK))
    u_dut_a (.clk(clk), .rstn(rstn), .enable(en_a), .ts(ifa), .eof(eof_a));

  ts_packet_source #(.NUM_CH(B_CH), .NUM_PKTS(B_PKTS), .GAP_CYCLES(B_GAP), .BASE_PID(B_PID),
                     .LOSS_PERIOD(0), .LOSS_MASK(2'b00))
    u_dut_b (.clk(clk), .rstn(rstn), .enable(en_b), .ts(ifb), .eof(eof_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NID-1:0] v, rd, so, eo;
  logic [7:0]     dd [NID];
  assign v  = {ifb.valid, ifa.valid};
  assign rd = {ifb.ready, ifa.ready};
  assign so = {ifb.sop, ifa.sop};
  assign eo = {ifb.eop, ifa.eop};
  always_comb begin
    for (int n = 0; n < A_CH; n++) dd[n] = ifa.byte_data[8*n +: 8];
    for (int n = 0; n < B_CH; n++) dd[A_CH+n] = ifb.byte_data[8*n +: 8];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the per-channel packet sequence, straight from the packet rules.
  function automatic int f_pkts(input int id);
    return (id < A_CH) ? A_PKTS : B_PKTS;
  endfunction
  function automatic int f_gap(input int id);
    return (id < A_CH) ? A_GAP : B_GAP;
  endfunction
  function automatic logic [12:0] f_pid(input int id);
    return (id < A_CH) ? 13'(A_PID + id) : 13'(B_PID + (id - A_CH));
  endfunction
  function automatic bit f_drop(input int id, input int p);
    return (id < A_CH) && A_MASK[id] && (((p + 1) % A_LP) == 0);
  endfunction
  function automatic int f_next_emit(input int id, input int p);
    int q = p + 1;
    while (q < f_pkts(id) && f_drop(id, q)) q++;
    return q;
  endfunction
  function automatic logic [9:0] f_exp(input int id, input int k, input int p);
    logic [12:0] pid;
    logic [7:0]  b;
    pid = f_pid(id);
    if (k == 0)      b = 8'h47;
    else if (k == 1) b = {3'b010, pid[12:8]};
    else if (k == 2) b = pid[7:0];
    else if (k == 3) b = 8'h10 + 8'(p % 16);
    else             b = 8'((k - 4 + p) % 256);
    return {k == 0, k == 187, b};
  endfunction

  int          m_pkt [NID];
  int          m_k [NID];
  int          last_pkt [NID];
  int          low_run [NID];
  int          eop_cyc [NID];
  int          fin_cyc [NID];
  bit          fin [NID];
  bit          after_eop [NID];
  bit          gap_en_ok [NID];
  bit          prev_hold [NID];
  logic [10:0] prev_vals [NID];
  bit          eof_seen [2];
  logic [10:0] mon_cur;
  logic        mon_en;
  int          mon_exp;
  bit          mon_all;

  task automatic model_reset();
    for (int id = 0; id < NID; id++) begin
      m_pkt[id]     = f_next_emit(id, -1);
      m_k[id]       = 0;
      last_pkt[id]  = 0;
      low_run[id]   = 0;
      fin[id]       = 1'b0;
      fin_cyc[id]   = 0;
      after_eop[id] = 1'b0;
      gap_en_ok[id] = 1'b0;
      prev_hold[id] = 1'b0;
    end
    eof_seen[0] = 1'b0;
    eof_seen[1] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      model_reset();
    end else begin
      for (int id = 0; id < NID; id++) begin
        mon_cur = {v[id], so[id], eo[id], dd[id]};
        mon_en  = (id < A_CH) ? en_a : en_b;
        if (prev_hold[id]) check($sformatf("hold_ch%0d", id), mon_cur, prev_vals[id]);
        prev_hold[id] = v[id] && !rd[id];
        prev_vals[id] = mon_cur;
        if (!mon_en) gap_en_ok[id] = 1'b0;
        if (v[id]) begin
          if (after_eop[id]) begin
            if (gap_en_ok[id])
              check($sformatf("gap_ch%0d", id), low_run[id], f_gap(id) * (m_pkt[id] - last_pkt[id]));
            after_eop[id] = 1'b0;
          end
          if (rd[id]) begin
            if (m_pkt[id] >= f_pkts(id)) begin
              check($sformatf("xfer_after_last_ch%0d", id), m_pkt[id], f_pkts(id) - 1);
            end else begin
              check($sformatf("byte_ch%0d_p%0d_k%0d", id, m_pkt[id], m_k[id]),
                    mon_cur[9:0], f_exp(id, m_k[id], m_pkt[id]));
              if (m_k[id] == 187) begin
                last_pkt[id]  = m_pkt[id];
                after_eop[id] = 1'b1;
                gap_en_ok[id] = 1'b1;
                low_run[id]   = 0;
                eop_cyc[id]   = cyc + 1;
                m_k[id]       = 0;
                m_pkt[id]     = f_next_emit(id, m_pkt[id]);
                if (m_pkt[id] >= f_pkts(id)) begin
                  fin[id]     = 1'b1;
                  fin_cyc[id] = cyc + 1 + f_gap(id) * (m_pkt[id] - last_pkt[id]);
                end
              end else begin
                m_k[id]++;
              end
            end
          end
        end else if (after_eop[id]) begin
          low_run[id]++;
        end
      end
      for (int x = 0; x < 2; x++) begin
        if (((x == 0) ? eof_a : eof_b) && !eof_seen[x]) begin
          eof_seen[x] = 1'b1;
          mon_all = 1'b1;
          mon_exp = 0;
          for (int id = ((x == 0) ? 0 : A_CH); id < ((x == 0) ? A_CH : NID); id++) begin
            if (!fin[id]) mon_all = 1'b0;
            if (fin_cyc[id] > mon_exp) mon_exp = fin_cyc[id];
          end
          check($sformatf("eof_time_%0d", x), cyc, mon_all ? mon_exp + 1 : -1);
        end
      end
    end
  end

  task automatic wait_sig(input int id, input bit want_eop, input string tag);
    int n = 0;
    @(negedge clk);
    while (!(v[id] && (want_eop ? eo[id] : so[id])) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < 2000, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {ifb.valid, ifa.valid}, 0);
    check({tag, "_flags"}, {so, eo}, 0);
    check({tag, "_data"}, {ifb.byte_data, ifa.byte_data}, 0);
    check({tag, "_eof"}, {eof_b, eof_a}, 0);
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    ifa.ready = '1;
    ifb.ready = '1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    rstn = 1'b1;
    @(posedge clk);
    #1 en_a = 1'b1;
    en_b = 1'b1;

    // Backpressure on A ch1 at byte 10 of packet 0.
    wait_sig(1, 1'b0, "wait_sop_bp");
    repeat (10) @(posedge clk);
    #1 ifa.ready[1] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("bp_hold_byte10", {v[1], dd[1]}, 9'h106);
    end
    @(posedge clk);
    #1 ifa.ready[1] = 1'b1;
    wait_sig(1, 1'b1, "wait_eop_bp");
    @(negedge clk);
    check("bp_ch1_lag", eop_cyc[1] - eop_cyc[0], 5);
    check("bp_ch2_lag", eop_cyc[2] - eop_cyc[0], 0);

    // Asynchronous reset at byte 100 of ch1 packet 1.
    wait_sig(1, 1'b0, "wait_sop_rst");
    repeat (100) @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Enable dropped at byte 50 of ch0 packet 0.
    wait_sig(0, 1'b0, "wait_sop_en");
    repeat (50) @(posedge clk);
    #1 en_a = 1'b0;
    repeat (400) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      check("en_low_valid", ifa.valid, 0);
      @(negedge clk);
    end
    check("en_low_ch1_pkt", m_pkt[1], 1);
    check("en_low_ch1_k", m_k[1], 0);
    @(posedge clk);
    #1 en_a = 1'b1;

    // Random backpressure until both instances finish.
    n = 0;
    while (!(eof_a && eof_b) && n < 30000) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < A_CH; c++) ifa.ready[c] = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < B_CH; c++) ifb.ready[c] = ($urandom_range(0, 3) != 0);
      n++;
    end
    check("eof_reached", n < 30000, 1'b1);
    @(negedge clk);
    for (int id = 0; id < NID; id++) check($sformatf("all_pkts_ch%0d", id), m_pkt[id], f_pkts(id));
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("done_quiet", {eof_b, eof_a, v}, {2'b11, {NID{1'b0}}});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
